// File: rtl/spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 byte transmitter. It sends one byte MSB first with ss framing and returns a one-cycle end pulse.
module spi_byte_tx #(
    parameter int SCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       begin_transmission,
    input  logic [7:0] send_data,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic       end_transmission,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;
    state_t      state_q;
    logic [15:0] half_q;
    logic [2:0]  bit_q;
    logic [7:0]  sr_q;
    logic        sclk_q, ss_q, busy_q, end_q;
    logic        half_end;
    assign half_end         = half_q == 16'(SCLK_HALF - 1);
    assign sclk             = sclk_q;
    assign mosi             = sr_q[7];
    assign ss               = ss_q;
    assign busy             = busy_q;
    assign end_transmission = end_q;
    // mosi is the shift register MSB; the last bit is not shifted out so it persists through HOLD
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            half_q  <= 16'd0;
            bit_q   <= 3'd0;
            sr_q    <= 8'd0;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state_q)
                IDLE: if (begin_transmission) begin
                    state_q <= SHIFT;
                    sr_q    <= send_data;
                    half_q  <= 16'd0;
                    bit_q   <= 3'd0;
                    sclk_q  <= 1'b0;
                    ss_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    half_q <= half_end ? 16'd0 : half_q + 16'd1;
                    if (half_end) begin
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            if (bit_q == 3'd7) state_q <= HOLD;
                            else begin
                                bit_q <= bit_q + 3'd1;
                                sr_q  <= {sr_q[6:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    half_q <= half_end ? 16'd0 : half_q + 16'd1;
                    if (half_end) begin
                        state_q <= DONE;
                        sr_q    <= 8'd0;
                        bit_q   <= 3'd0;
                        ss_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        end_q   <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: scoreboard bench over three spi_byte_tx instances (SCLK_HALF = 1, 2, 4).
module tb_spi_byte_tx;
    logic       clk = 1'b0;
    logic [2:0] rstn = 3'b000;
    logic [2:0] bt = 3'b000;
    logic [7:0] sd [3];
    logic [2:0] sclk_w, mosi_w, ss_w, end_w, busy_w;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] sh [3];
    int         rises [3];
    int         end_cnt [3];
    int         end_cyc [3];
    int         fall_cyc [3];
    int         rise_cyc [3];
    logic       prev_sclk [3];
    logic       prev_ss [3];
    logic       prev_mosi [3];
    logic       prev_end [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_byte_tx #(.SCLK_HALF(1)) u0 (.clk(clk), .rst(rstn[0]), .begin_transmission(bt[0]), .send_data(sd[0]),
        .sclk(sclk_w[0]), .mosi(mosi_w[0]), .ss(ss_w[0]), .end_transmission(end_w[0]), .busy(busy_w[0]));
    spi_byte_tx #(.SCLK_HALF(2)) u1 (.clk(clk), .rst(rstn[1]), .begin_transmission(bt[1]), .send_data(sd[1]),
        .sclk(sclk_w[1]), .mosi(mosi_w[1]), .ss(ss_w[1]), .end_transmission(end_w[1]), .busy(busy_w[1]));
    spi_byte_tx #(.SCLK_HALF(4)) u2 (.clk(clk), .rst(rstn[2]), .begin_transmission(bt[2]), .send_data(sd[2]),
        .sclk(sclk_w[2]), .mosi(mosi_w[2]), .ss(ss_w[2]), .end_transmission(end_w[2]), .busy(busy_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bus monitor: decodes bytes on sclk rises and compares them with the scoreboard on end pulses
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_en) begin
                if (ss_w[i] === 1'b0 && prev_ss[i] === 1'b1) begin
                    rises[i]    <= 0;
                    sh[i]       <= 8'd0;
                    fall_cyc[i] <= cyc;
                end
                if (ss_w[i] === 1'b1 && prev_ss[i] === 1'b0) rise_cyc[i] <= cyc;
                if (sclk_w[i] !== prev_sclk[i]) chk("sclk_toggle_ss", 32'(prev_ss[i]), 0);
                if (sclk_w[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
                    chk("mosi_stable", 32'(mosi_w[i]), 32'(prev_mosi[i]));
                    sh[i]    <= {sh[i][6:0], mosi_w[i]};
                    rises[i] <= rises[i] + 1;
                end
                if (end_w[i] === 1'b1) begin
                    chk("end_width", 32'(prev_end[i]), 0);
                    chk("done_outs", {28'd0, ss_w[i], busy_w[i], sclk_w[i], mosi_w[i]}, 32'b1000);
                    chk("sclk_rises", rises[i], 8);
                    if (exp_q.size() == 0) chk("end_unexpected", 1, 0);
                    else chk("byte", 32'(sh[i]), 32'(exp_q.pop_front()));
                    end_cnt[i] <= end_cnt[i] + 1;
                    end_cyc[i] <= cyc;
                end
            end
            prev_sclk[i] <= sclk_w[i];
            prev_ss[i]   <= ss_w[i];
            prev_mosi[i] <= mosi_w[i];
            prev_end[i]  <= end_w[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit expect_end, output int t0);
        bt[i] = 1'b1;
        sd[i] = d;
        if (expect_end) exp_q.push_back(d);
        tick();
        t0 = cyc;
        bt[i] = 1'b0;
    endtask

    task automatic wait_end(input int i, input int budget);
        int c0 = end_cnt[i];
        int n = 0;
        while (end_cnt[i] == c0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("end_seen", end_cnt[i] - c0, 1);
    endtask

    initial begin
        int t0, e1, e2, e3, c;
        for (int i = 0; i < 3; i++) begin
            sd[i] = 8'd0;
            rises[i] = 0;
            end_cnt[i] = 0;
            end_cyc[i] = 0;
            fall_cyc[i] = 0;
            rise_cyc[i] = 0;
        end
        bt[0] = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ss", 32'(ss_w[i]), 1);
            chk("rst_busy", 32'(busy_w[i]), 0);
            chk("rst_outs", {29'd0, sclk_w[i], mosi_w[i], end_w[i]}, 0);
        end
        bt[0] = 1'b0;
        rstn = 3'b111;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();

        send(1, 8'hA5, 1'b1, t0);
        wait_end(1, 60);
        chk("a5_end_cycle", end_cyc[1] - t0 + 1, 35);
        chk("a5_ss_first_low", fall_cyc[1] - t0 + 1, 1);
        chk("a5_ss_last_low", rise_cyc[1] - t0, 34);
        repeat (3) tick();

        bt[0] = 1'b1;
        sd[0] = 8'h1B;
        exp_q.push_back(8'h1B);
        wait_end(0, 40);
        e1 = end_cyc[0];
        sd[0] = 8'h5B;
        exp_q.push_back(8'h5B);
        wait_end(0, 40);
        e2 = end_cyc[0];
        sd[0] = 8'h6A;
        exp_q.push_back(8'h6A);
        wait_end(0, 40);
        e3 = end_cyc[0];
        bt[0] = 1'b0;
        chk("b2b_gap1", e2 - e1, 19);
        chk("b2b_gap2", e3 - e2, 19);
        repeat (5) tick();
        chk("b2b_stopped", end_cnt[0], 3);

        send(1, 8'hFF, 1'b1, t0);
        repeat (2) tick();
        sd[1] = 8'h00;
        wait_end(1, 60);
        repeat (3) tick();

        send(2, 8'h77, 1'b0, t0);
        repeat (19) tick();
        rstn[2] = 1'b0;
        tick();
        chk("abort_ss", 32'(ss_w[2]), 1);
        chk("abort_sclk", 32'(sclk_w[2]), 0);
        chk("abort_busy", 32'(busy_w[2]), 0);
        rstn[2] = 1'b1;
        c = end_cnt[2];
        repeat (80) tick();
        chk("abort_no_end", end_cnt[2] - c, 0);
        send(2, 8'h3C, 1'b1, t0);
        wait_end(2, 100);
        chk("3c_end_cycle", end_cyc[2] - t0 + 1, 69);
        repeat (3) tick();

        send(1, 8'h5A, 1'b1, t0);
        repeat (4) tick();
        bt[1] = 1'b1;
        tick();
        bt[1] = 1'b0;
        c = end_cnt[1];
        wait_end(1, 60);
        repeat (40) tick();
        chk("ignored_req_one_end", end_cnt[1] - c, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
